// File: rtl/lap_timer_bank.sv
// lap_timer_bank: eleven mm:ss.cc BCD time registers (ten lap slots plus a
// total) advanced by a shared 1/100 s tick, with a freezable display port.
module lap_timer_bank #(
  parameter int CLK_DIV = 500000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [10:0] en,
  input  logic [3:0]  disp_sel,
  input  logic        disp_update,
  output logic [23:0] disp_time,
  output logic        tick,
  output logic [10:0] ovf
);

  localparam int NREG = 11;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_p0;
  logic          tick_p1;
  logic [23:0]   time_p2 [0:NREG-1];
  logic [10:0]   ovf_p2;
  logic [23:0]   disp_p3;
  logic [24:0]   inc_next [0:NREG-1];
  logic [3:0]    sel_idx;
  logic          any_en;

  // One-step BCD increment; the MSB of the result flags 59:59.99 -> 00:00.00.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [3:0] mt, mu, st, su, ct, cu;
    logic       wrap;
    {mt, mu, st, su, ct, cu} = t;
    wrap = 1'b0;
    if (cu != 4'd9) begin
      cu = cu + 4'd1;
    end else begin
      cu = 4'd0;
      if (ct != 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (su != 4'd9) begin
          su = su + 4'd1;
        end else begin
          su = 4'd0;
          if (st != 4'd5) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            if (mu != 4'd9) begin
              mu = mu + 4'd1;
            end else begin
              mu = 4'd0;
              if (mt != 4'd5) begin
                mt = mt + 4'd1;
              end else begin
                mt = 4'd0;
                wrap = 1'b1;
              end
            end
          end
        end
      end
    end
    return {wrap, mt, mu, st, su, ct, cu};
  endfunction

  assign any_en    = |en;
  assign sel_idx   = (disp_sel > 4'd10) ? 4'd10 : disp_sel;
  assign tick      = tick_p1;
  assign ovf       = ovf_p2;
  assign disp_time = disp_p3;

  // Stage p0/p1: prescaler only runs while something counts, so the sub-tick
  // phase survives stop/start; tick is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pre_p0  <= '0;
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= 1'b0;
      if (any_en) begin
        if (pre_p0 == PRE_LAST) begin
          pre_p0  <= '0;
          tick_p1 <= 1'b1;
        end else begin
          pre_p0 <= pre_p0 + PW'(1);
        end
      end
    end
  end

  // Candidate next value of every register, computed unconditionally.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      inc_next[i] = bcd_inc(time_p2[i]);
    end
  end

  // Stage p2: on a tick, each register whose enable is set in that same
  // cycle advances by 0.01 s; a wrap sets its sticky overflow flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NREG; i++) begin
        time_p2[i] <= '0;
      end
      ovf_p2 <= '0;
    end else if (tick_p1) begin
      for (int i = 0; i < NREG; i++) begin
        if (en[i]) begin
          time_p2[i] <= inc_next[i][23:0];
          if (inc_next[i][24]) begin
            ovf_p2[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Stage p3: display register follows the selected slot live, or holds.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      disp_p3 <= '0;
    end else if (disp_update) begin
      disp_p3 <= time_p2[sel_idx];
    end
  end

endmodule

// File: tb/tb_lap_timer_bank.sv
// tb_lap_timer_bank: table-driven scenario rows checked every cycle against a
// centisecond-count model through a scoreboard queue, plus hand-written
// sequences for phase preservation, reset during tick and the 59:59.99 wrap.
module tb_lap_timer_bank;

  localparam int DIV4 = 4;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [10:0] en;
  logic [3:0]  disp_sel;
  logic        disp_update;
  logic [23:0] disp_time;
  logic        tick;
  logic [10:0] ovf;

  logic [10:0] en1;
  logic [3:0]  disp_sel1;
  logic        disp_update1;
  logic [23:0] disp_time1;
  logic        tick1;
  logic [10:0] ovf1;

  always #5 clk = ~clk;

  lap_timer_bank #(.CLK_DIV(DIV4)) dut (
    .clk(clk), .n_reset(n_reset), .en(en), .disp_sel(disp_sel),
    .disp_update(disp_update), .disp_time(disp_time), .tick(tick), .ovf(ovf)
  );

  lap_timer_bank #(.CLK_DIV(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .en(en1), .disp_sel(disp_sel1),
    .disp_update(disp_update1), .disp_time(disp_time1), .tick(tick1), .ovf(ovf1)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        tick;
    logic [10:0] ovf;
    logic [23:0] disp;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [10:0] en;
    logic [3:0]  sel;
    logic        upd;
    int          cycles;
    logic [23:0] exp_disp;
  } vec_t;
  vec_t tbl[11];

  // model state: registers kept as plain centisecond counts
  int          m_pre;
  logic        m_tick;
  int          m_cs[11];
  logic [10:0] m_ovf;
  logic [23:0] m_disp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_pre = 0;
    m_tick = 1'b0;
    for (int i = 0; i < 11; i++) m_cs[i] = 0;
    m_ovf = '0;
    m_disp = '0;
    exp_q.delete();
  endtask

  // advance the model one edge with the current inputs, then compare the DUT
  task automatic step();
    exp_t e;
    int   sel;
    sel = (disp_sel > 4'd10) ? 10 : int'(disp_sel);
    if (disp_update) m_disp = to_bcd(m_cs[sel]);
    if (m_tick) begin
      for (int i = 0; i < 11; i++) begin
        if (en[i]) begin
          if (m_cs[i] == 359999) begin
            m_cs[i] = 0;
            m_ovf[i] = 1'b1;
          end else begin
            m_cs[i] = m_cs[i] + 1;
          end
        end
      end
    end
    if (|en) begin
      if (m_pre == DIV4 - 1) begin
        m_pre = 0;
        m_tick = 1'b1;
      end else begin
        m_pre = m_pre + 1;
        m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
    e.tick = m_tick;
    e.ovf  = m_ovf;
    e.disp = m_disp;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("tick", 32'(tick), 32'(e.tick));
    check("ovf", 32'(ovf), 32'(e.ovf));
    check("disp", 32'(disp_time), 32'(e.disp));
  endtask

  initial begin
    bit seen;

    tbl[0]  = '{11'h000, 4'd0,  1'b1, 20,  24'h000000};
    tbl[1]  = '{11'h401, 4'd0,  1'b1, 401, 24'h000099};
    tbl[2]  = '{11'h000, 4'd0,  1'b1, 2,   24'h000100};
    tbl[3]  = '{11'h000, 4'd10, 1'b1, 1,   24'h000100};
    tbl[4]  = '{11'h000, 4'd5,  1'b1, 1,   24'h000000};
    tbl[5]  = '{11'h7FF, 4'd1,  1'b1, 12,  24'h000002};
    tbl[6]  = '{11'h000, 4'd1,  1'b1, 1,   24'h000003};
    tbl[7]  = '{11'h000, 4'd15, 1'b1, 1,   24'h000103};
    tbl[8]  = '{11'h400, 4'd12, 1'b1, 4,   24'h000103};
    tbl[9]  = '{11'h400, 4'd3,  1'b0, 200, 24'h000103};
    tbl[10] = '{11'h000, 4'd12, 1'b1, 1,   24'h000154};

    n_reset = 1'b1;
    en = '0;
    disp_sel = '0;
    disp_update = 1'b1;
    en1 = '0;
    disp_sel1 = 4'd10;
    disp_update1 = 1'b1;
    #2 n_reset = 1'b0;
    #1;
    check("reset_disp", 32'(disp_time), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();

    // scenario table
    for (int r = 0; r < 11; r++) begin
      en = tbl[r].en;
      disp_sel = tbl[r].sel;
      disp_update = tbl[r].upd;
      for (int c = 0; c < tbl[r].cycles; c++) step();
      check($sformatf("row%0d_disp", r), 32'(disp_time), 32'(tbl[r].exp_disp));
    end

    // reset asserted while tick is high: nothing may be applied
    en = 11'h401;
    disp_sel = 4'd0;
    disp_update = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      if (m_tick) seen = 1'b1;
    end
    check("tick_before_reset", 32'(tick), 32'h1);
    #1 n_reset = 1'b0;
    #1;
    check("midtick_rst_tick", 32'(tick), 32'h0);
    check("midtick_rst_disp", 32'(disp_time), 32'h0);
    check("midtick_rst_ovf", 32'(ovf), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    en = '0;
    step();
    check("rst_reg0", 32'(disp_time), 32'h0);
    disp_sel = 4'd10;
    step();
    check("rst_reg10", 32'(disp_time), 32'h0);

    // prescaler phase survives a stop
    en = 11'h001;
    repeat (2) step();
    en = '0;
    repeat (10) step();
    en = 11'h001;
    step();
    check("phase_first", 32'(tick), 32'h0);
    step();
    check("phase_second", 32'(tick), 32'h1);
    en = '0;
    step();

    // total register wrap with a tick every enabled cycle
    en1 = 11'h400;
    @(posedge clk);
    #1;
    check("div1_tick", 32'(tick1), 32'h1);
    check("div1_disp0", 32'(disp_time1), 32'h0);
    repeat (359999) @(posedge clk);
    #1;
    check("wrap_pre_disp", 32'(disp_time1), 32'h595998);
    check("wrap_pre_ovf", 32'(ovf1), 32'h0);
    @(posedge clk);
    #1;
    check("wrap_max_disp", 32'(disp_time1), 32'h595999);
    check("wrap_ovf", 32'(ovf1), 32'h400);
    en1 = '0;
    @(posedge clk);
    #1;
    check("wrap_zero_disp", 32'(disp_time1), 32'h0);
    check("wrap_ovf_sticky", 32'(ovf1), 32'h400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
